// File: rtl/cdma_dc_pkg.sv
// Shared definitions for the CDMA DC response sequencer: FSM encodings and descriptor layout.
package cdma_dc_pkg;

    localparam int DESC_W         = 6;
    localparam int DESC_EOL_BIT   = 5;
    localparam int DESC_BEATS_MSB = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DESC = 2'd1;
    localparam logic [1:0] ST_BEAT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic       eol;
        logic [4:0] beats_m1;
    } desc_t;

    function automatic desc_t desc_unpack(input logic [DESC_W-1:0] pd);
        desc_t d;
        d.eol      = pd[DESC_EOL_BIT];
        d.beats_m1 = pd[DESC_BEATS_MSB:0];
        return d;
    endfunction

endpackage

// File: rtl/cdma_dc_rsp_ostage.sv
// One-entry valid/ready output register carrying CBUF address, payload, last and eol tags.
module cdma_dc_rsp_ostage #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] wrap_addr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_eol,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_eol
);

    logic out_fire_s;
    logic [ADDR_W-1:0] addr_next_s;

    assign out_fire_s  = out_valid && out_ready;
    assign addr_next_s = (out_addr == wrap_addr) ? {ADDR_W{1'b0}}
                                                 : out_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Control/tag register: a new beat may only arrive when the slot is empty or draining.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_eol   <= 1'b0;
            out_addr  <= {ADDR_W{1'b0}};
        end else begin
            if (in_valid) begin
                out_valid <= 1'b1;
                out_last  <= in_last;
                out_eol   <= in_eol;
            end else if (out_fire_s) begin
                out_valid <= 1'b0;
            end
            if (addr_load) begin
                out_addr <= base_addr;
            end else if (out_fire_s) begin
                out_addr <= addr_next_s;
            end
        end
    end

    // Payload register is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            out_data <= in_data;
        end
    end

endmodule

// File: rtl/cdma_dc_rsp_seq.sv
// CDMA DC response sequencer: pops descriptors, counts response beats, forwards them to CBUF.
// Optional build macro CDMA_DC_RSP_PERF_EN adds the perf_stall_cnt output.
module cdma_dc_rsp_seq
    import cdma_dc_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 12,
    parameter int LINE_W = 14
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              op_load,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W-1:0] cfg_wrap_addr,
    input  logic [LINE_W-1:0] cfg_line_num,
    input  logic              desc_req,
    output logic              desc_rdy,
    input  logic [DESC_W-1:0] desc_pd,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_last,
    output logic              wr_eol,
    output logic              op_done
`ifdef CDMA_DC_RSP_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    logic [1:0]        state_r;
    logic [ADDR_W-1:0] cfg_wrap_r;
    logic [LINE_W-1:0] cfg_line_num_r;
    logic [LINE_W-1:0] line_cnt_r;
    logic              eol_r;
    logic [4:0]        beats_m1_r;
    logic [4:0]        beat_cnt_r;

    logic   op_start_s;
    logic   rsp_fire_s;
    logic   beat_last_s;
    logic   out_free_s;
    desc_t  desc_s;

    assign desc_s      = desc_unpack(desc_pd);
    assign op_start_s  = op_load && (state_r == ST_IDLE);
    assign out_free_s  = !wr_valid || wr_ready;
    assign desc_rdy    = (state_r == ST_DESC);
    assign rsp_ready   = (state_r == ST_BEAT) && out_free_s;
    assign rsp_fire_s  = rsp_valid && rsp_ready;
    assign beat_last_s = (beat_cnt_r == beats_m1_r);

    // Sequencer FSM: descriptor pop, beat counting and end-of-operation detection.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_r        <= ST_IDLE;
            cfg_wrap_r     <= {ADDR_W{1'b0}};
            cfg_line_num_r <= {LINE_W{1'b0}};
            line_cnt_r     <= {LINE_W{1'b0}};
            eol_r          <= 1'b0;
            beats_m1_r     <= 5'd0;
            beat_cnt_r     <= 5'd0;
            op_done        <= 1'b0;
        end else begin
            op_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (op_load) begin
                        cfg_wrap_r     <= cfg_wrap_addr;
                        cfg_line_num_r <= cfg_line_num;
                        line_cnt_r     <= {LINE_W{1'b0}};
                        state_r        <= ST_DESC;
                    end
                end
                ST_DESC: begin
                    if (desc_req) begin
                        eol_r      <= desc_s.eol;
                        beats_m1_r <= desc_s.beats_m1;
                        beat_cnt_r <= 5'd0;
                        state_r    <= ST_BEAT;
                    end
                end
                ST_BEAT: begin
                    if (rsp_fire_s) begin
                        beat_cnt_r <= beat_cnt_r + 5'd1;
                        if (beat_last_s) begin
                            if (eol_r) begin
                                line_cnt_r <= line_cnt_r + {{(LINE_W-1){1'b0}}, 1'b1};
                            end
                            state_r <= (eol_r && (line_cnt_r == cfg_line_num_r)) ? ST_DONE : ST_DESC;
                        end
                    end
                end
                ST_DONE: begin
                    // Completion waits for the final beat to leave the output stage.
                    if (out_free_s) begin
                        op_done <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    cdma_dc_rsp_ostage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ostage (
        .clk       (clk),
        .reset_    (reset_),
        .addr_load (op_start_s),
        .base_addr (cfg_base_addr),
        .wrap_addr (cfg_wrap_r),
        .in_valid  (rsp_fire_s),
        .in_data   (rsp_data),
        .in_last   (beat_last_s),
        .in_eol    (beat_last_s && eol_r),
        .out_ready (wr_ready),
        .out_valid (wr_valid),
        .out_addr  (wr_addr),
        .out_data  (wr_data),
        .out_last  (wr_last),
        .out_eol   (wr_eol)
    );

`ifdef CDMA_DC_RSP_PERF_EN
    // Saturating count of cycles where the CBUF arbiter back-pressures a pending write.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            perf_stall_cnt <= 32'd0;
        end else if (op_start_s) begin
            perf_stall_cnt <= 32'd0;
        end else if (wr_valid && !wr_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdma_dc_rsp_seq.sv
// Scoreboard bench for cdma_dc_rsp_seq; covers the stall counter when CDMA_DC_RSP_PERF_EN is defined.
module tb_cdma_dc_rsp_seq;

    localparam int DATA_W = 512;
    localparam int ADDR_W = 12;
    localparam int LINE_W = 14;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              last;
        logic              eol;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk;
    logic              reset_;
    logic              op_load;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [ADDR_W-1:0] cfg_wrap_addr;
    logic [LINE_W-1:0] cfg_line_num;
    logic              desc_req;
    logic              desc_rdy;
    logic [5:0]        desc_pd;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_eol;
    logic              op_done;
`ifdef CDMA_DC_RSP_PERF_EN
    logic [31:0]       perf_stall_cnt;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   rsp_seq = 0;
    int   exp_seq = 0;
    bit   chk_en = 1'b1;
    bit   tog_en = 1'b0;
    exp_t exp_q[$];

    cdma_dc_rsp_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk            (clk),
        .reset_         (reset_),
        .op_load        (op_load),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_wrap_addr  (cfg_wrap_addr),
        .cfg_line_num   (cfg_line_num),
        .desc_req       (desc_req),
        .desc_rdy       (desc_rdy),
        .desc_pd        (desc_pd),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_last        (wr_last),
        .wr_eol         (wr_eol),
        .op_done        (op_done)
`ifdef CDMA_DC_RSP_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pat(input int s);
        return {16{32'hC0DE_0000 + 32'(s)}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic push(input int addr, input bit last, input bit eol);
        exp_t e;
        e.addr = ADDR_W'(addr);
        e.last = last;
        e.eol  = eol;
        e.data = pat(exp_seq);
        exp_seq++;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every accepted write, checks back-pressure on rsp_ready.
    always @(negedge clk) begin
        if (reset_ && chk_en) begin
            if (wr_valid && wr_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: addr %0d last %0b eol %0b", wr_addr, wr_last, wr_eol);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({wr_addr, wr_last, wr_eol, wr_data} !== e) begin
                        n_err++;
                        $display("FAIL write: got addr %0d last %0b eol %0b data %0h, expected addr %0d last %0b eol %0b data %0h",
                                 wr_addr, wr_last, wr_eol, wr_data[31:0], e.addr, e.last, e.eol, e.data[31:0]);
                    end
                end
            end
            if (wr_valid && !wr_ready) begin
                check("rsp_ready_stalled", 64'(rsp_ready), 64'd0);
            end
        end
        if (reset_ && op_done) done_cnt++;
    end

    task automatic start_op(input int base, input int wrap, input int line);
        @(posedge clk); #1;
        cfg_base_addr = ADDR_W'(base);
        cfg_wrap_addr = ADDR_W'(wrap);
        cfg_line_num  = LINE_W'(line);
        op_load = 1'b1;
        @(posedge clk); #1;
        op_load = 1'b0;
    endtask

    task automatic drive_descs(input logic [5:0] ds[$]);
        foreach (ds[i]) begin
            int t = 0;
            desc_req = 1'b1;
            desc_pd  = ds[i];
            @(negedge clk);
            while (!desc_rdy && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (!desc_rdy) timeout("desc_handshake");
            @(posedge clk); #1;
        end
        desc_req = 1'b0;
    endtask

    task automatic drive_rsp(input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            rsp_valid = 1'b1;
            rsp_data  = pat(rsp_seq);
            @(negedge clk);
            while (!rsp_ready && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (!rsp_ready) timeout("rsp_handshake");
            @(posedge clk); #1;
            rsp_seq++;
        end
        rsp_valid = 1'b0;
    endtask

    task automatic run_op(input int base, input int wrap, input int line,
                          input logic [5:0] ds[$], input int nbeats, input bit poke);
        int d0 = done_cnt;
        int t = 0;
        start_op(base, wrap, line);
        fork
            drive_descs(ds);
            drive_rsp(nbeats);
            begin
                if (poke) begin
                    repeat (3) @(posedge clk);
                    #1;
                    cfg_base_addr = 12'd500;
                    op_load = 1'b1;
                    @(posedge clk); #1;
                    op_load = 1'b0;
                end
            end
        join
        while (done_cnt == d0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("op_done_once", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        logic [5:0] dq[$];
        reset_ = 1'b0;
        op_load = 1'b0;
        cfg_base_addr = '0;
        cfg_wrap_addr = '0;
        cfg_line_num = '0;
        desc_req = 1'b0;
        desc_pd = '0;
        rsp_valid = 1'b0;
        rsp_data = '0;
        wr_ready = 1'b1;
        #2;
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_desc_rdy", 64'(desc_rdy), 64'd0);
        check("rst_rsp_ready", 64'(rsp_ready), 64'd0);
        check("rst_op_done", 64'(op_done), 64'd0);
        check("rst_last_eol", 64'({wr_last, wr_eol}), 64'd0);
        @(posedge clk); #1;
        reset_ = 1'b1;

        // 4-beat non-eol desc at base 10, closed by a 1-beat eol desc
        push(10, 0, 0); push(11, 0, 0); push(12, 0, 0); push(13, 1, 0); push(14, 1, 1);
        dq = '{6'h03, 6'h20};
        run_op(10, 1023, 0, dq, 5, 1'b0);

        // address wrap 1022,1023,0,1
        push(1022, 0, 0); push(1023, 0, 0); push(0, 0, 0); push(1, 1, 1);
        dq = '{6'h23};
        run_op(1022, 1023, 0, dq, 4, 1'b0);

        // two lines; an op_load during the run must be ignored
        push(100, 1, 1); push(101, 0, 0); push(102, 1, 0); push(103, 1, 1);
        dq = '{6'h20, 6'h01, 6'h20};
        run_op(100, 4095, 1, dq, 4, 1'b1);

        // 32-beat desc with wr_ready toggling every cycle
        for (int i = 0; i < 32; i++) push(i, i == 31, i == 31);
        dq = '{6'h3F};
        tog_en = 1'b1;
        fork
            begin
                run_op(0, 4095, 0, dq, 32, 1'b0);
                tog_en = 1'b0;
            end
            begin
                while (tog_en) begin
                    @(posedge clk); #1;
                    wr_ready = tog_en ? ~wr_ready : 1'b1;
                end
                wr_ready = 1'b1;
            end
        join

        // reset in the middle of BEAT, then a fresh operation
        begin
            int t = 0;
            chk_en = 1'b0;
            start_op(200, 4095, 0);
            desc_req = 1'b1;
            desc_pd = 6'h27;
            rsp_valid = 1'b1;
            rsp_data = '0;
            @(negedge clk);
            while (!rsp_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!rsp_ready) timeout("beat_state");
            @(posedge clk); #1;
            desc_req = 1'b0;
            @(posedge clk); #1;
            check("pre_reset_wr_valid", 64'(wr_valid), 64'd1);
            reset_ = 1'b0;
            #1;
            check("mid_rst_wr_valid", 64'(wr_valid), 64'd0);
            check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
            check("mid_rst_rsp_ready", 64'(rsp_ready), 64'd0);
            check("mid_rst_desc_rdy", 64'(desc_rdy), 64'd0);
            check("mid_rst_tags", 64'({wr_last, wr_eol, op_done}), 64'd0);
            rsp_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            reset_ = 1'b1;
            exp_q.delete();
            chk_en = 1'b1;
        end
        push(5, 0, 0); push(6, 1, 1);
        dq = '{6'h21};
        run_op(5, 4095, 0, dq, 2, 1'b0);

`ifdef CDMA_DC_RSP_PERF_EN
        // stall counter: 7 back-pressured cycles, cleared by the next op_load
        push(0, 1, 1);
        dq = '{6'h20};
        wr_ready = 1'b0;
        fork
            run_op(0, 4095, 0, dq, 1, 1'b0);
            begin
                int t = 0;
                @(negedge clk);
                while (!wr_valid && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                if (!wr_valid) timeout("perf_wr_valid");
                repeat (7) @(posedge clk);
                #1;
                wr_ready = 1'b1;
            end
        join
        check("perf_stall_cnt", 64'(perf_stall_cnt), 64'd7);
        start_op(0, 4095, 0);
        check("perf_clear", 64'(perf_stall_cnt), 64'd0);
        reset_ = 1'b0;
        @(posedge clk); #1;
        reset_ = 1'b1;
`endif

        repeat (2) @(posedge clk);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
